ahb3lite_interconnect_arbiter: RTL and testbench
================================================

AHB3LITE_INTERCONNECT_ARBITER -- requirements
Module: ahb3lite_interconnect_arbiter

Interface
REQ-001 Parameter MASTERS, default 3: number of requesting masters; range 2..16.
REQ-002 Parameter AGE_LIMIT, default 15: starvation threshold in HREADY cycles; range 1..255.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 HRESETn  input  1  asynchronous active-low reset.
REQ-005 HCLK  input  1  clock; all state updates on the rising edge.
REQ-006 req  input  MASTERS  per-master HSEL request for this slave.
REQ-007 mstpriority  input  MASTERS x 3  per-master priority, 7 = highest.
REQ-008 HTRANS  input  2  HTRANS of the currently granted master.
REQ-009 HBURST  input  3  HBURST of the currently granted master.
REQ-010 HMASTLOCK  input  1  HMASTLOCK of the currently granted master.
REQ-011 HREADY  input  1  slave-side HREADY; qualifies every state update.
REQ-012 granted_master  output  MASTERS  one-hot address-phase grant.
REQ-013 granted_idx  output  clog2(MASTERS)  binary form of granted_master.
REQ-014 granted_idx_dly  output  clog2(MASTERS)  granted_idx delayed one HREADY cycle, used for the HWDATA mux.

Function
REQ-015 Updates to grant, FSM, beat counter, round-robin pointers and age counters SHALL occur only in cycles with HREADY=1.
REQ-016 Candidate set SHALL be the requesting masters at the highest requested priority level.
REQ-017 Within the candidate set, selection SHALL be round-robin: the first requester after that level's last-granted master, wrapping from MASTERS-1 to 0.
REQ-018 One last-granted pointer SHALL be kept per priority level (8 levels); it updates only when that level wins a switch.
REQ-019 If no master requests, the grant SHALL stay unchanged (parking).
REQ-020 FSM states SHALL be IDLE, BURST and LOCKED; a switch is permitted only when the FSM is in IDLE or on the final BURST beat.
REQ-021 IDLE to BURST: NONSEQ with HBURST = INCR4/WRAP4, INCR8/WRAP8 or INCR16/WRAP16 loads the beat counter with 3, 7 or 15 respectively.
REQ-022 In BURST, each SEQ decrements the beat counter; at 0, or on HTRANS = IDLE/NONSEQ (early termination), the FSM SHALL return to IDLE and switching is permitted that cycle.
REQ-023 SINGLE and INCR SHALL stay in IDLE (switchable at any beat boundary); in IDLE, SEQ SHALL be treated as no-switch.
REQ-024 Any state to LOCKED: HMASTLOCK=1 with HTRANS != IDLE.
REQ-025 LOCKED to IDLE: HMASTLOCK=0 with HTRANS = IDLE; no switch SHALL occur while in LOCKED.
REQ-026 On a switch, granted_master and granted_idx SHALL change at the clock edge, giving one cycle of latency from a request to the address-phase grant.
REQ-027 granted_idx_dly SHALL follow granted_idx one HREADY cycle later.
REQ-028 Outputs SHALL hold their values while HREADY=0.

Reset
REQ-029 On HRESETn=0, asynchronously: granted_master=1 (master 0), granted_idx=0, granted_idx_dly=0.
REQ-030 Also on reset: every last-granted pointer = master 0, FSM = IDLE, beat counter = 0, age counters = 0.
REQ-031 Reset asserted mid-burst or mid-lock SHALL abandon the sequence; after release, arbitration restarts from the reset state.

Configuration
REQ-032 Macro AHB3LITE_ARB_AGING_EN: when defined, each master has an 8-bit age counter.
REQ-033 With the macro, the counter increments (saturating at AGE_LIMIT) each HREADY cycle the master requests but is not granted, and clears when the master is granted or stops requesting.
REQ-034 With the macro, masters at AGE_LIMIT outrank all priority levels; among several aged masters, round-robin uses a dedicated aged pointer; the REQ-020..025 switch rules still apply.
REQ-035 Without the macro, no age logic SHALL be present and arbitration is strict priority plus round-robin.

Verification
REQ-036 Reset release, req=3'b000 -> granted_master=3'b001 and stays there.
REQ-037 req=3'b110, all priorities 0, HTRANS=NONSEQ SINGLE each cycle, HREADY=1 -> grant alternates 3'b010, 3'b100, 3'b010.
REQ-038 Master 0 granted, NONSEQ INCR4, then 3 SEQ; master 1 requesting at priority 7 from beat 2 -> grant changes to 3'b010 only on the edge after the 4th beat.
REQ-039 HMASTLOCK=1 for 5 transfers, higher-priority request pending -> no switch until the cycle after HMASTLOCK=0 with HTRANS=IDLE.
REQ-040 HREADY=0 for 3 cycles during a switch opportunity -> grant and granted_idx_dly frozen; switch happens on the first HREADY=1 edge.
REQ-041 Macro defined, AGE_LIMIT=4, master 2 at priority 0 while master 0 at priority 3 streams SINGLEs -> master 2 granted on the edge after 4 unserved HREADY cycles.

Source files
------------

// File: rtl/ahb3lite_interconnect_arbiter_if.sv
// rtl/ahb3lite_interconnect_arbiter_if.sv - Request/grant bundle between AHB masters and the slave-port arbiter
interface ahb3lite_interconnect_arbiter_if #(
  parameter int MASTERS = 3
);
  localparam int IDXW = $clog2(MASTERS);

  logic [MASTERS-1:0]      req;
  logic [MASTERS-1:0][2:0] mstpriority;
  logic [1:0]              HTRANS;
  logic [2:0]              HBURST;
  logic                    HMASTLOCK;
  logic                    HREADY;
  logic [MASTERS-1:0]      granted_master;
  logic [IDXW-1:0]         granted_idx;
  logic [IDXW-1:0]         granted_idx_dly;

  modport master (
    output req, mstpriority, HTRANS, HBURST, HMASTLOCK, HREADY,
    input  granted_master, granted_idx, granted_idx_dly
  );

  modport slave (
    input  req, mstpriority, HTRANS, HBURST, HMASTLOCK, HREADY,
    output granted_master, granted_idx, granted_idx_dly
  );
endinterface

// File: rtl/ahb3lite_interconnect_arbiter.sv
// rtl/ahb3lite_interconnect_arbiter.sv - Priority + per-level round-robin AHB3-Lite slave-port arbiter; define AHB3LITE_ARB_AGING_EN for starvation aging
module ahb3lite_interconnect_arbiter #(
  parameter int MASTERS   = 3,
  parameter int AGE_LIMIT = 15
) (
  input logic HCLK,
  input logic HRESETn,
  ahb3lite_interconnect_arbiter_if.slave bus
);
  localparam int         IDXW      = $clog2(MASTERS);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  if (MASTERS < 2 || MASTERS > 16 || AGE_LIMIT < 1 || AGE_LIMIT > 255) begin : g_bad_cfg
    $error("ahb3lite_interconnect_arbiter: MASTERS or AGE_LIMIT out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_LOCKED} state_t;

  state_t             state;
  logic [3:0]         beat_cnt;
  logic [MASTERS-1:0] grant_q;
  logic [IDXW-1:0]    idx_q;
  logic [IDXW-1:0]    idx_dly_q;
  logic [IDXW-1:0]    level_ptr [8];

  logic [2:0]         top_lvl;
  logic [MASTERS-1:0] cand;
  logic [IDXW-1:0]    rr_ptr;
  logic [IDXW-1:0]    winner;
  logic               found;
  int                 sel_idx;
  logic [3:0]         burst_len;
  logic               lock_req;
  logic               fixed_burst;
  logic               switch_ok;
  logic               do_switch;

`ifdef AHB3LITE_ARB_AGING_EN
  localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);
  logic [7:0]         age [MASTERS];
  logic [MASTERS-1:0] aged;
  logic [IDXW-1:0]    aged_ptr;

  always_comb begin
    aged = '0;
    for (int m = 0; m < MASTERS; m++)
      aged[m] = bus.req[m] && (age[m] >= AGE_MAX);
  end

  // Age restarts whenever the master is served or withdraws its request.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int m = 0; m < MASTERS; m++) age[m] <= '0;
    end else if (bus.HREADY) begin
      for (int m = 0; m < MASTERS; m++) begin
        if (!bus.req[m] || grant_q[m]) age[m] <= '0;
        else if (age[m] < AGE_MAX)     age[m] <= age[m] + 8'd1;
      end
    end
  end
`endif

  always_comb begin
    top_lvl = '0;
    for (int l = 0; l < 8; l++)
      for (int m = 0; m < MASTERS; m++)
        if (bus.req[m] && bus.mstpriority[m] == 3'(l)) top_lvl = 3'(l);
    cand = '0;
    for (int m = 0; m < MASTERS; m++)
      cand[m] = bus.req[m] && (bus.mstpriority[m] == top_lvl);
    rr_ptr = level_ptr[top_lvl];
`ifdef AHB3LITE_ARB_AGING_EN
    if (|aged) begin
      cand   = aged;
      rr_ptr = aged_ptr;
    end
`endif
    // First candidate strictly after the pointer, wrapping; the pointer itself is checked last.
    winner  = rr_ptr;
    found   = 1'b0;
    sel_idx = 0;
    for (int off = 1; off <= MASTERS; off++) begin
      sel_idx = int'(rr_ptr) + off;
      if (sel_idx >= MASTERS) sel_idx = sel_idx - MASTERS;
      if (!found && cand[sel_idx]) begin
        winner = IDXW'(sel_idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    case (bus.HBURST)
      3'd2, 3'd3: burst_len = 4'd3;
      3'd4, 3'd5: burst_len = 4'd7;
      3'd6, 3'd7: burst_len = 4'd15;
      default:    burst_len = 4'd0;
    endcase
    lock_req    = bus.HMASTLOCK && (bus.HTRANS != TR_IDLE);
    fixed_burst = (bus.HTRANS == TR_NONSEQ) && (burst_len != 4'd0);
    case (state)
      ST_IDLE:  switch_ok = !lock_req && !fixed_burst &&
                            (bus.HTRANS == TR_IDLE || bus.HTRANS == TR_NONSEQ);
      ST_BURST: switch_ok = !lock_req &&
                            ((bus.HTRANS == TR_SEQ && beat_cnt <= 4'd1) ||
                             bus.HTRANS == TR_IDLE || bus.HTRANS == TR_NONSEQ);
      default:  switch_ok = 1'b0;
    endcase
    do_switch = bus.HREADY && switch_ok && (|bus.req);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      grant_q   <= MASTERS'(1);
      idx_q     <= '0;
      idx_dly_q <= '0;
      for (int l = 0; l < 8; l++) level_ptr[l] <= '0;
`ifdef AHB3LITE_ARB_AGING_EN
      aged_ptr  <= '0;
`endif
    end else if (bus.HREADY) begin
      idx_dly_q <= idx_q;
      case (state)
        ST_IDLE: begin
          if (lock_req) state <= ST_LOCKED;
          else if (fixed_burst) begin
            state    <= ST_BURST;
            beat_cnt <= burst_len;
          end
        end
        ST_BURST: begin
          if (lock_req) begin
            state    <= ST_LOCKED;
            beat_cnt <= '0;
          end else if (bus.HTRANS == TR_SEQ) begin
            if (beat_cnt <= 4'd1) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt - 4'd1;
            end
          end else if (bus.HTRANS != TR_BUSY) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (!bus.HMASTLOCK && bus.HTRANS == TR_IDLE) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (do_switch) begin
        grant_q <= MASTERS'(1) << winner;
        idx_q   <= winner;
`ifdef AHB3LITE_ARB_AGING_EN
        if (|aged) aged_ptr <= winner;
        else       level_ptr[top_lvl] <= winner;
`else
        level_ptr[top_lvl] <= winner;
`endif
      end
    end
  end

  assign bus.granted_master  = grant_q;
  assign bus.granted_idx     = idx_q;
  assign bus.granted_idx_dly = idx_dly_q;
endmodule

// File: tb/tb_ahb3lite_interconnect_arbiter.sv
// tb/tb_ahb3lite_interconnect_arbiter.sv - Directed vector bench for the AHB3-Lite slave-port arbiter
module tb_ahb3lite_interconnect_arbiter;
  localparam int MASTERS = 3;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SGL  = 3'd0;
  localparam logic [2:0] B_I4   = 3'd3;

  // Priority words are {p2, p1, p0}
  localparam logic [8:0] P0     = 9'd0;
  localparam logic [8:0] P_M0_7 = {3'd0, 3'd0, 3'd7};
  localparam logic [8:0] P_M1_7 = {3'd0, 3'd7, 3'd0};
  localparam logic [8:0] P_M2_7 = {3'd7, 3'd0, 3'd0};
  localparam logic [8:0] P_AGE  = {3'd0, 3'd0, 3'd3};

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  ahb3lite_interconnect_arbiter_if #(.MASTERS(MASTERS)) bus ();

  ahb3lite_interconnect_arbiter #(.MASTERS(MASTERS), .AGE_LIMIT(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic [2:0] req;
    logic [8:0] prio;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       lock;
    logic       ready;
    logic [2:0] gm;
    logic [1:0] idx;
    logic [1:0] dly;
  } vec_t;

  vec_t vt [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input string n, input logic [2:0] r, input logic [8:0] p,
                              input logic [1:0] t, input logic [2:0] b, input logic l,
                              input logic rd, input logic [2:0] g, input logic [1:0] i,
                              input logic [1:0] d);
    vec_t v;
    v.name = n; v.req = r; v.prio = p; v.htrans = t; v.hburst = b;
    v.lock = l; v.ready = rd; v.gm = g; v.idx = i; v.dly = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string n, input logic [2:0] g, input logic [1:0] i,
                           input logic [1:0] d);
    chk({n, ".granted_master"},  {1'b0, bus.granted_master}, {1'b0, g});
    chk({n, ".granted_idx"},     {2'b00, bus.granted_idx},    {2'b00, i});
    chk({n, ".granted_idx_dly"}, {2'b00, bus.granted_idx_dly}, {2'b00, d});
  endtask

  task automatic drive(input logic [2:0] r, input logic [8:0] p, input logic [1:0] t,
                       input logic [2:0] b, input logic l, input logic rd);
    bus.req         = r;
    bus.mstpriority = p;
    bus.HTRANS      = t;
    bus.HBURST      = b;
    bus.HMASTLOCK   = l;
    bus.HREADY      = rd;
  endtask

  initial begin
    //          name        req     prio    htrans  hburst lock rdy  gm      idx    dly
    vt.push_back(mk("park0",   3'b000, P0,     T_IDLE, B_SGL, 0, 1, 3'b001, 2'd0, 2'd0));
    vt.push_back(mk("park1",   3'b000, P0,     T_IDLE, B_SGL, 0, 1, 3'b001, 2'd0, 2'd0));
    vt.push_back(mk("rr0",     3'b110, P0,     T_NS,   B_SGL, 0, 1, 3'b010, 2'd1, 2'd0));
    vt.push_back(mk("rr1",     3'b110, P0,     T_NS,   B_SGL, 0, 1, 3'b100, 2'd2, 2'd1));
    vt.push_back(mk("rr2",     3'b110, P0,     T_NS,   B_SGL, 0, 1, 3'b010, 2'd1, 2'd2));
    vt.push_back(mk("m0only",  3'b001, P0,     T_NS,   B_SGL, 0, 1, 3'b001, 2'd0, 2'd1));
    vt.push_back(mk("incr4_b1",3'b001, P0,     T_NS,   B_I4,  0, 1, 3'b001, 2'd0, 2'd0));
    vt.push_back(mk("incr4_b2",3'b011, P_M1_7, T_SEQ,  B_I4,  0, 1, 3'b001, 2'd0, 2'd0));
    vt.push_back(mk("incr4_b3",3'b011, P_M1_7, T_SEQ,  B_I4,  0, 1, 3'b001, 2'd0, 2'd0));
    vt.push_back(mk("incr4_b4",3'b011, P_M1_7, T_SEQ,  B_I4,  0, 1, 3'b010, 2'd1, 2'd0));
    for (int k = 0; k < 5; k++)
      vt.push_back(mk($sformatf("lock%0d", k), 3'b011, P_M0_7, T_NS, B_SGL, 1, 1, 3'b010, 2'd1, 2'd1));
    vt.push_back(mk("unlock",  3'b011, P_M0_7, T_IDLE, B_SGL, 0, 1, 3'b010, 2'd1, 2'd1));
    vt.push_back(mk("postlock",3'b011, P_M0_7, T_IDLE, B_SGL, 0, 1, 3'b001, 2'd0, 2'd1));
    for (int k = 0; k < 3; k++)
      vt.push_back(mk($sformatf("stall%0d", k), 3'b110, P0, T_NS, B_SGL, 0, 0, 3'b001, 2'd0, 2'd1));
    vt.push_back(mk("unstall", 3'b110, P0,     T_NS,   B_SGL, 0, 1, 3'b010, 2'd1, 2'd0));
    vt.push_back(mk("bstart",  3'b010, P0,     T_NS,   B_I4,  0, 1, 3'b010, 2'd1, 2'd1));
    vt.push_back(mk("earlyterm",3'b110,P_M2_7, T_IDLE, B_I4,  0, 1, 3'b100, 2'd2, 2'd1));
    vt.push_back(mk("idleseq", 3'b110, P_M1_7, T_SEQ,  B_SGL, 0, 1, 3'b100, 2'd2, 2'd2));
    vt.push_back(mk("afterseq",3'b110, P_M1_7, T_NS,   B_SGL, 0, 1, 3'b010, 2'd1, 2'd2));

    HRESETn = 1'b0;
    drive(3'b000, P0, T_IDLE, B_SGL, 1'b0, 1'b1);
    #12;
    check_out("reset", 3'b001, 2'd0, 2'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    for (int v = 0; v < vt.size(); v++) begin
      drive(vt[v].req, vt[v].prio, vt[v].htrans, vt[v].hburst, vt[v].lock, vt[v].ready);
      @(posedge HCLK); #1;
      check_out(vt[v].name, vt[v].gm, vt[v].idx, vt[v].dly);
    end

    // Reset in the middle of a locked sequence must drop the lock and the pointers.
    drive(3'b110, P0, T_NS, B_SGL, 1'b1, 1'b1);
    @(posedge HCLK); #1;
    check_out("lock_enter", 3'b010, 2'd1, 2'd1);
    @(posedge HCLK); #1;
    check_out("lock_hold", 3'b010, 2'd1, 2'd1);
    #3 HRESETn = 1'b0;
    #1 check_out("async_reset", 3'b001, 2'd0, 2'd0);
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    drive(3'b110, P0, T_NS, B_SGL, 1'b0, 1'b1);
    @(posedge HCLK); #1;
    check_out("post_reset_switch", 3'b010, 2'd1, 2'd0);

`ifdef AHB3LITE_ARB_AGING_EN
    HRESETn = 1'b0;
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    drive(3'b101, P_AGE, T_NS, B_SGL, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge HCLK); #1;
      chk($sformatf("age_wait%0d", k), {1'b0, bus.granted_master}, 4'b0001);
    end
    @(posedge HCLK); #1;
    chk("aged_grant", {1'b0, bus.granted_master}, 4'b0100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
